// File: rtl/mem_addr_bus_arbiter.sv
// Registered arbiter for the shared memory address bus: instruction fetch vs load/store.
// Latches the winning address at grant, holds it until mem_ready, bounds starvation and stalls.
module mem_addr_bus_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned PC_W       = 8,
    parameter int unsigned DATA_FIRST = 1,
    parameter int unsigned MAX_STARVE = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              pc_req,
    input  logic [PC_W-1:0]   pc_addr,
    output logic              pc_gnt,
    output logic              pc_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              err,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;

    localparam int unsigned STV_W = $clog2(MAX_STARVE + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [STV_W-1:0] STV_MAX = STV_W'(MAX_STARVE);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);
    localparam logic FETCH_FIRST = (DATA_FIRST == 0);

    logic [1:0]        r_state;
    logic [STV_W-1:0]  r_starve;
    logic [TMO_W-1:0]  r_tmo;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic              r_pc_gnt;
    logic              r_ls_gnt;
    logic              r_pc_done;
    logic              r_ls_done;
    logic              r_err;

    logic w_starve_full;
    logic w_pick_pc;
    logic w_any_req;

    always_comb begin
        w_starve_full = (r_starve == STV_MAX);
        w_any_req     = pc_req | ls_req;
        // A starved fetch overrides the static priority when both requesters are waiting.
        w_pick_pc     = pc_req & (~ls_req | w_starve_full | FETCH_FIRST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_starve   <= '0;
            r_tmo      <= '0;
            r_mem_addr <= '0;
            r_mem_we   <= 1'b0;
            r_pc_gnt   <= 1'b0;
            r_ls_gnt   <= 1'b0;
            r_pc_done  <= 1'b0;
            r_ls_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_pc_gnt  <= 1'b0;
            r_ls_gnt  <= 1'b0;
            r_pc_done <= 1'b0;
            r_ls_done <= 1'b0;
            r_err     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_tmo <= '0;
                        if (w_pick_pc) begin
                            r_state    <= S_FETCH;
                            r_mem_addr <= ADDR_W'(pc_addr);
                            r_mem_we   <= 1'b0;
                            r_pc_gnt   <= 1'b1;
                            r_starve   <= '0;
                        end else begin
                            r_state    <= S_DATA;
                            r_mem_addr <= ls_addr;
                            r_mem_we   <= ls_we;
                            r_ls_gnt   <= 1'b1;
                            if (!pc_req) begin
                                r_starve <= '0;
                            end else if (!w_starve_full) begin
                                r_starve <= r_starve + STV_W'(1);
                            end
                        end
                    end
                end
                S_FETCH, S_DATA: begin
                    // Ready in the abort cycle completes normally rather than erroring.
                    if (mem_ready) begin
                        r_state   <= S_IDLE;
                        r_pc_done <= (r_state == S_FETCH);
                        r_ls_done <= (r_state == S_DATA);
                    end else if (r_tmo == TMO_MAX) begin
                        r_state <= S_IDLE;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign pc_gnt    = r_pc_gnt;
    assign ls_gnt    = r_ls_gnt;
    assign pc_done   = r_pc_done;
    assign ls_done   = r_ls_done;
    assign err       = r_err;
    assign mem_addr  = r_mem_addr;
    assign mem_we    = r_mem_we;
    assign mem_valid = (r_state != S_IDLE);
    assign busy      = (r_state != S_IDLE);

endmodule
